pointer_sequencer: RTL and testbench

Parametrised successor to the per-unit pointer array: generates one weight-memory read address and one bias address per processing unit for a full multi-channel kernel sweep. A single start/busy/done handshake replaces manual re-seeding per kernel. Per-unit base spacing, channel count and an abort path are added. Sits between the layer controller (start, config, step) and the weight/bias SRAM read ports of the PE array.

---
 rtl/pointer_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_pointer_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pointer_sequencer.sv
// pointer_sequencer: per-unit weight and bias address generator that
// walks a full multi-channel kernel with a start/busy/done handshake.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   start           begin a sweep (taken in IDLE only)
//   abort           cancel a running sweep, no done pulse
//   step            advance one element (RUN only)
//   start_addr      weight base of unit 0
//   unit_stride     weight base spacing between units
//   kernel_size     elements per channel
//   n_channels      channels per kernel
//   bias_base       bias address of unit 0, channel 0
//   active_units    lane enable mask, latched at start
//   addr_out        weight address per unit
//   addr_valid      per-unit valid (RUN and lane enabled)
//   bias_addr       bias address per unit
//   ch_idx          current channel index
//   last_elem       current element closes its channel
//   busy            sweep in progress
//   done            one-cycle completion pulse
module pointer_sequencer #(
  parameter int N_UNITS = 4,
  parameter int ADDR_W  = 16,
  parameter int KS_W    = 8,
  parameter int CH_W    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           step,
  input  logic [ADDR_W-1:0]              start_addr,
  input  logic [ADDR_W-1:0]              unit_stride,
  input  logic [KS_W-1:0]                kernel_size,
  input  logic [CH_W-1:0]                n_channels,
  input  logic [ADDR_W-1:0]              bias_base,
  input  logic [N_UNITS-1:0]             active_units,
  output logic [N_UNITS-1:0][ADDR_W-1:0] addr_out,
  output logic [N_UNITS-1:0]             addr_valid,
  output logic [N_UNITS-1:0][ADDR_W-1:0] bias_addr,
  output logic [CH_W-1:0]                ch_idx,
  output logic                           last_elem,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [KS_W-1:0] ks_q, ks_d;
  logic [KS_W-1:0] e_q, e_d;
  logic [CH_W-1:0] nch_q, nch_d;
  logic [CH_W-1:0] c_q, c_d;
  logic [N_UNITS-1:0] mask_q, mask_d;
  logic [N_UNITS-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [N_UNITS-1:0][ADDR_W-1:0] bias_q, bias_d;
  logic last_q, last_d;

  logic zero_cfg;
  logic take_start;
  logic adv;
  logic e_last;
  logic c_last;
  logic final_step;
  logic [ADDR_W-1:0] lane_base;
  logic [ADDR_W-1:0] lane_bias;

  assign zero_cfg = (kernel_size == '0)
                 || (n_channels == '0);
  assign take_start = (state_q == ST_IDLE)
                   && start;
  // abort outranks step while running
  assign adv = (state_q == ST_RUN)
            && step && !abort;
  assign e_last = (e_q == ks_q - KS_W'(1));
  assign c_last = (c_q == nch_q - CH_W'(1));
  assign final_step = adv && e_last && c_last;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = zero_cfg ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (final_step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    addr_valid = busy ? mask_q : '0;
    addr_out   = addr_q;
    bias_addr  = bias_q;
    ch_idx     = c_q;
    last_elem  = last_q;
  end

  // Datapath. Lane bases are formed once at start with a running
  // sum; after that every lane only ever increments by one, weights
  // on every step and biases on each channel rollover.
  always_comb begin
    ks_d      = ks_q;
    nch_d     = nch_q;
    mask_d    = mask_q;
    e_d       = e_q;
    c_d       = c_q;
    addr_d    = addr_q;
    bias_d    = bias_q;
    last_d    = last_q;
    lane_base = start_addr;
    lane_bias = bias_base;
    if (take_start) begin
      ks_d   = kernel_size;
      nch_d  = n_channels;
      mask_d = active_units;
      e_d    = '0;
      c_d    = '0;
      last_d = !zero_cfg
            && (kernel_size == KS_W'(1));
      for (int j = 0; j < N_UNITS; j++) begin
        addr_d[j] = active_units[j]
                  ? lane_base : '0;
        bias_d[j] = active_units[j]
                  ? lane_bias : '0;
        lane_base = lane_base + unit_stride;
        lane_bias = lane_bias
                  + ADDR_W'(n_channels);
      end
    end else if (final_step) begin
      // addresses hold their last values
      last_d = 1'b0;
    end else if (adv) begin
      for (int j = 0; j < N_UNITS; j++) begin
        if (mask_q[j]) begin
          addr_d[j] = addr_q[j] + ADDR_W'(1);
        end
      end
      if (e_last) begin
        e_d    = '0;
        c_d    = c_q + CH_W'(1);
        last_d = (ks_q == KS_W'(1));
        for (int j = 0; j < N_UNITS; j++) begin
          if (mask_q[j]) begin
            bias_d[j] = bias_q[j] + ADDR_W'(1);
          end
        end
      end else begin
        e_d    = e_q + KS_W'(1);
        last_d = ((e_q + KS_W'(1))
               == (ks_q - KS_W'(1)));
      end
    end else if ((state_q == ST_RUN) && abort) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks_q   <= '0;
      nch_q  <= '0;
      mask_q <= '0;
      e_q    <= '0;
      c_q    <= '0;
      addr_q <= '0;
      bias_q <= '0;
      last_q <= 1'b0;
    end else begin
      ks_q   <= ks_d;
      nch_q  <= nch_d;
      mask_q <= mask_d;
      e_q    <= e_d;
      c_q    <= c_d;
      addr_q <= addr_d;
      bias_q <= bias_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_pointer_sequencer.sv
// tb_pointer_sequencer: vector table, directed corners and a
// randomized run against a behavioural address model.
module tb_pointer_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, step;
  logic [15:0] start_addr, unit_stride, bias_base;
  logic [7:0] kernel_size, n_channels;
  logic [3:0] active_units;
  logic [3:0][15:0] addr_out, bias_addr;
  logic [3:0] addr_valid;
  logic [7:0] ch_idx;
  logic last_elem, busy, done;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pointer_sequencer #(
    .N_UNITS(4), .ADDR_W(16),
    .KS_W(8), .CH_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .start(start), .abort(abort), .step(step),
    .start_addr(start_addr),
    .unit_stride(unit_stride),
    .kernel_size(kernel_size),
    .n_channels(n_channels),
    .bias_base(bias_base),
    .active_units(active_units),
    .addr_out(addr_out),
    .addr_valid(addr_valid),
    .bias_addr(bias_addr),
    .ch_idx(ch_idx),
    .last_elem(last_elem),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] sa,
                     input logic [15:0] st,
                     input logic [7:0] ks,
                     input logic [7:0] nc,
                     input logic [15:0] bb,
                     input logic [3:0] m);
    start_addr   = sa;
    unit_stride  = st;
    kernel_size  = ks;
    n_channels   = nc;
    bias_base    = bb;
    active_units = m;
  endtask

  // drive one cycle, then sample at the following negedge
  task automatic tick(input logic s,
                      input logic p,
                      input logic a);
    start = s;
    step  = p;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
    abort = 1'b0;
  endtask

  typedef struct {
    logic st, sp, ab;
    logic e_busy, e_done;
    logic [3:0] e_valid;
    logic [3:0][15:0] e_a, e_b;
    logic [7:0] e_ch;
    logic e_last;
    logic ca, ccl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic st, sp, ab, bz, dn,
    input logic [3:0] v,
    input logic [3:0][15:0] a, b,
    input logic [7:0] ch,
    input logic l, ca, ccl);
    vec_t r;
    r.st = st; r.sp = sp; r.ab = ab;
    r.e_busy = bz; r.e_done = dn;
    r.e_valid = v;
    r.e_a = a; r.e_b = b;
    r.e_ch = ch; r.e_last = l;
    r.ca = ca; r.ccl = ccl;
    return r;
  endfunction

  // behavioural model: outputs are a function of the linear index
  int m_ph;   // 0 idle, 1 run, 2 done
  int m_k;
  int m_mode; // 0 all-zero, 1 formula, 2 unchecked
  int m_ks, m_nch;
  logic [31:0] m_sa, m_st, m_bb;
  logic [3:0] m_mask;

  task automatic m_reset();
    m_ph = 0; m_k = 0; m_mode = 0;
  endtask

  task automatic m_update();
    case (m_ph)
      0: if (start) begin
        m_sa = 32'(start_addr);
        m_st = 32'(unit_stride);
        m_bb = 32'(bias_base);
        m_ks = int'(kernel_size);
        m_nch = int'(n_channels);
        m_mask = active_units;
        if (m_ks == 0 || m_nch == 0) begin
          m_ph = 2; m_mode = 2;
        end else begin
          m_ph = 1; m_k = 0; m_mode = 1;
        end
      end
      1: if (abort) begin
        m_ph = 0; m_mode = 2;
      end else if (step) begin
        if (m_k == m_ks * m_nch - 1) m_ph = 2;
        else m_k++;
      end
      default: begin
        m_ph = 0; m_mode = 2;
      end
    endcase
  endtask

  task automatic m_check();
    logic [31:0] ea, eb;
    chk("rnd_busy", 64'(busy), 64'(m_ph == 1));
    chk("rnd_done", 64'(done), 64'(m_ph == 2));
    chk("rnd_valid", 64'(addr_valid),
        64'((m_ph == 1) ? m_mask : 4'b0));
    if (m_mode != 2) begin
      for (int j = 0; j < 4; j++) begin
        ea = 0; eb = 0;
        if (m_mode == 1 && m_mask[j]) begin
          ea = m_sa + 32'(j) * m_st + 32'(m_k);
          eb = m_bb + 32'(j * m_nch + m_k / m_ks);
        end
        chk($sformatf("rnd_addr%0d", j),
            64'(addr_out[j]), 64'(ea[15:0]));
        chk($sformatf("rnd_bias%0d", j),
            64'(bias_addr[j]), 64'(eb[15:0]));
      end
    end
    if (m_mode == 0) begin
      chk("rnd_ch", 64'(ch_idx), 64'(0));
      chk("rnd_last", 64'(last_elem), 64'(0));
    end else if (m_ph == 1) begin
      chk("rnd_ch", 64'(ch_idx), 64'(m_k / m_ks));
      chk("rnd_last", 64'(last_elem),
          64'((m_k % m_ks) == m_ks - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] wr [4];
    logic [3:0][15:0] z;
    z = '0;
    rst = 1'b0;
    start = 1'b0; step = 1'b0; abort = 1'b0;
    cfg(16'd100, 16'd3, 8'd3, 8'd2, 16'd500, 4'b1101);
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", 64'(addr_out), 64'(0));
    chk("rst_bias", 64'(bias_addr), 64'(0));
    chk("rst_ctl", 64'({addr_valid, busy, done,
                        last_elem, ch_idx}), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // basic sweep, handshake corners, abort at k=2
    tbl.push_back(mk(0,1,0, 0,0, 4'b0000, z, z, 0, 0, 1,1));
    tbl.push_back(mk(0,0,1, 0,0, 4'b0000, z, z, 0, 0, 1,1));
    tbl.push_back(mk(1,0,0, 1,0, 4'b1101,
      {16'd109,16'd106,16'd0,16'd100},
      {16'd506,16'd504,16'd0,16'd500}, 0, 0, 1,1));
    tbl.push_back(mk(0,1,0, 1,0, 4'b1101,
      {16'd110,16'd107,16'd0,16'd101},
      {16'd506,16'd504,16'd0,16'd500}, 0, 0, 1,1));
    tbl.push_back(mk(0,1,0, 1,0, 4'b1101,
      {16'd111,16'd108,16'd0,16'd102},
      {16'd506,16'd504,16'd0,16'd500}, 0, 1, 1,1));
    tbl.push_back(mk(0,1,0, 1,0, 4'b1101,
      {16'd112,16'd109,16'd0,16'd103},
      {16'd507,16'd505,16'd0,16'd501}, 1, 0, 1,1));
    tbl.push_back(mk(1,1,0, 1,0, 4'b1101,
      {16'd113,16'd110,16'd0,16'd104},
      {16'd507,16'd505,16'd0,16'd501}, 1, 0, 1,1));
    tbl.push_back(mk(0,0,0, 1,0, 4'b1101,
      {16'd113,16'd110,16'd0,16'd104},
      {16'd507,16'd505,16'd0,16'd501}, 1, 0, 1,1));
    tbl.push_back(mk(0,1,0, 1,0, 4'b1101,
      {16'd114,16'd111,16'd0,16'd105},
      {16'd507,16'd505,16'd0,16'd501}, 1, 1, 1,1));
    tbl.push_back(mk(0,1,0, 0,1, 4'b0000,
      {16'd114,16'd111,16'd0,16'd105},
      {16'd507,16'd505,16'd0,16'd501}, 0, 0, 1,0));
    tbl.push_back(mk(0,0,0, 0,0, 4'b0000, z, z, 0, 0, 0,0));
    tbl.push_back(mk(1,0,0, 1,0, 4'b1101,
      {16'd109,16'd106,16'd0,16'd100},
      {16'd506,16'd504,16'd0,16'd500}, 0, 0, 1,1));
    tbl.push_back(mk(0,1,0, 1,0, 4'b1101,
      {16'd110,16'd107,16'd0,16'd101},
      {16'd506,16'd504,16'd0,16'd500}, 0, 0, 1,1));
    tbl.push_back(mk(0,1,0, 1,0, 4'b1101,
      {16'd111,16'd108,16'd0,16'd102},
      {16'd506,16'd504,16'd0,16'd500}, 0, 1, 1,1));
    tbl.push_back(mk(0,1,1, 0,0, 4'b0000, z, z, 0, 0, 0,0));
    tbl.push_back(mk(0,0,0, 0,0, 4'b0000, z, z, 0, 0, 0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].st, tbl[i].sp, tbl[i].ab);
      chk($sformatf("vec%0d_busy", i),
          64'(busy), 64'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i),
          64'(done), 64'(tbl[i].e_done));
      chk($sformatf("vec%0d_valid", i),
          64'(addr_valid), 64'(tbl[i].e_valid));
      if (tbl[i].ca) begin
        chk($sformatf("vec%0d_addr", i),
            64'(addr_out), 64'(tbl[i].e_a));
        chk($sformatf("vec%0d_bias", i),
            64'(bias_addr), 64'(tbl[i].e_b));
      end
      if (tbl[i].ccl) begin
        chk($sformatf("vec%0d_ch", i),
            64'(ch_idx), 64'(tbl[i].e_ch));
        chk($sformatf("vec%0d_last", i),
            64'(last_elem), 64'(tbl[i].e_last));
      end
    end

    // start and step together in IDLE: step is dropped
    cfg(16'd100, 16'd3, 8'd3, 8'd2, 16'd500, 4'b1101);
    tick(1, 1, 0);
    chk("ss_addr0", 64'(addr_out[0]), 64'(100));
    chk("ss_busy", 64'(busy), 64'(1));
    tick(0, 0, 1);
    tick(0, 0, 0);

    // wrap-around at the top of the address space
    cfg(16'hFFFE, 16'd1, 8'd4, 8'd1, 16'd0, 4'b0011);
    wr[0] = 16'hFFFE; wr[1] = 16'hFFFF;
    wr[2] = 16'h0000; wr[3] = 16'h0001;
    tick(1, 0, 0);
    chk("wrap_lane1", 64'(addr_out[1]), 64'(16'hFFFF));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(0, 1, 0);
      chk($sformatf("wrap_a0_%0d", i),
          64'(addr_out[0]), 64'(wr[i]));
      chk($sformatf("wrap_last_%0d", i),
          64'(last_elem), 64'(i == 3));
    end
    tick(0, 1, 0);
    chk("wrap_done", 64'({busy, done}), 64'(2'b01));
    tick(0, 0, 0);
    chk("wrap_done_off", 64'({busy, done}), 64'(0));

    // zero-size sweeps
    cfg(16'd7, 16'd1, 8'd0, 8'd2, 16'd0, 4'b1111);
    tick(1, 1, 0);
    chk("zk_done", 64'({addr_valid, busy, done}), 64'(1));
    tick(0, 1, 0);
    chk("zk_after", 64'({addr_valid, busy, done}), 64'(0));
    cfg(16'd7, 16'd1, 8'd3, 8'd0, 16'd0, 4'b1111);
    tick(1, 0, 0);
    chk("zc_done", 64'({addr_valid, busy, done}), 64'(1));
    tick(0, 0, 0);
    chk("zc_after", 64'({addr_valid, busy, done}), 64'(0));

    // asynchronous reset at k=4
    cfg(16'd100, 16'd3, 8'd3, 8'd2, 16'd500, 4'b1101);
    tick(1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0);
    chk("mr_k4", 64'(addr_out[0]), 64'(104));
    #2 rst = 1'b0;
    #1;
    chk("mr_addr", 64'(addr_out), 64'(0));
    chk("mr_bias", 64'(bias_addr), 64'(0));
    chk("mr_ctl", 64'({addr_valid, busy, done,
                       last_elem, ch_idx}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    tick(0, 0, 0);
    chk("mr_nodone", 64'({busy, done}), 64'(0));
    tick(1, 0, 0);
    chk("mr_fresh", 64'(addr_out),
        64'({16'd109, 16'd106, 16'd0, 16'd100}));
    chk("mr_fresh_ch", 64'(ch_idx), 64'(0));

    // randomized run against the model
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    m_check();
    for (int it = 0; it < 600; it++) begin
      start_addr   = ($urandom_range(0, 3) == 0)
                   ? 16'hFFFC + 16'($urandom_range(0, 3))
                   : 16'($urandom);
      unit_stride  = 16'($urandom);
      bias_base    = 16'($urandom);
      kernel_size  = 8'($urandom_range(0, 4));
      n_channels   = 8'($urandom_range(0, 3));
      active_units = 4'($urandom);
      start = ($urandom_range(0, 4) == 0);
      step  = ($urandom_range(0, 9) < 7);
      abort = ($urandom_range(0, 29) == 0);
      m_update();
      @(negedge clk);
      start = 1'b0; step = 1'b0; abort = 1'b0;
      m_check();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
